// File: rtl/branch_resolve.sv
// Branch resolution: carries fetch-time predictions through D/E, detects mispredicts in E,
// drives a registered predictor-update port and a short recovery FSM.
// Optional performance counters are built only when BR_PERF_CNT_EN is defined.
module branch_resolve #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             taken_F,
    input  logic [31:0]      pred_target_F,
    input  logic             stall_D,
    input  logic             branch_E,
    input  logic             jump_E,
    input  logic             taken_E,
    input  logic [31:0]      pc_E,
    input  logic [31:0]      pc_target_E,
    output logic             flush,
    output logic [31:0]      pc_restore,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic [31:0]      upd_pc,
    output logic [31:0]      upd_target
`ifdef BR_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
`endif
);

    typedef enum logic [0:0] {
        StNormal  = 1'b0,
        StRecover = 1'b1
    } state_e;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end

    // Prediction slots.
    logic        r_valid_D;
    logic        r_pred_taken_D;
    logic [31:0] r_pred_target_D;
    logic        r_valid_E;
    logic        r_pred_taken_E;
    logic [31:0] r_pred_target_E;

    // Recovery FSM.
    state_e      r_state;
    logic        r_rcv_cnt;

    // Predictor update.
    logic        r_upd_valid;
    logic        r_upd_taken;
    logic [31:0] r_upd_pc;
    logic [31:0] r_upd_target;

    logic        w_actual_taken;
    logic        w_dir_miss;
    logic        w_tgt_miss;
    logic        w_nonbr_miss;
    logic        w_recover;
    logic        w_flush;
    logic        w_upd_fire;
    logic [31:0] w_restore_pc;

    assign w_recover      = (r_state == StRecover);
    assign w_actual_taken = jump_E | (branch_E & taken_E);
    assign w_dir_miss     = r_pred_taken_E != w_actual_taken;
    assign w_tgt_miss     = r_pred_taken_E & w_actual_taken & (r_pred_target_E != pc_target_E);
    assign w_nonbr_miss   = r_pred_taken_E & ~branch_E & ~jump_E;
    assign w_flush        = r_valid_E & ~w_recover & (w_dir_miss | w_tgt_miss | w_nonbr_miss);
    assign w_restore_pc   = w_actual_taken ? pc_target_E : (pc_E + 32'd4);
    assign w_upd_fire     = r_valid_E & (branch_E | jump_E);

    assign flush      = w_flush;
    assign pc_restore = w_flush ? w_restore_pc : 32'd0;
    assign upd_valid  = r_upd_valid;
    assign upd_taken  = r_upd_taken;
    assign upd_pc     = r_upd_pc;
    assign upd_target = r_upd_target;

    // Flush beats stall: both slots become bubbles so nothing stale survives a redirect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid_D       <= 1'b0;
            r_pred_taken_D  <= 1'b0;
            r_pred_target_D <= 32'd0;
            r_valid_E       <= 1'b0;
            r_pred_taken_E  <= 1'b0;
            r_pred_target_E <= 32'd0;
        end else if (w_flush) begin
            r_valid_D       <= 1'b0;
            r_pred_taken_D  <= 1'b0;
            r_pred_target_D <= 32'd0;
            r_valid_E       <= 1'b0;
            r_pred_taken_E  <= 1'b0;
            r_pred_target_E <= 32'd0;
        end else if (stall_D) begin
            r_valid_E       <= 1'b0;
            r_pred_taken_E  <= 1'b0;
            r_pred_target_E <= 32'd0;
        end else begin
            r_valid_D       <= 1'b1;
            r_pred_taken_D  <= taken_F;
            r_pred_target_D <= pred_target_F;
            r_valid_E       <= r_valid_D;
            r_pred_taken_E  <= r_pred_taken_D;
            r_pred_target_E <= r_pred_target_D;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= StNormal;
            r_rcv_cnt <= 1'b0;
        end else begin
            case (r_state)
                StNormal: begin
                    r_rcv_cnt <= 1'b0;
                    if (w_flush) begin
                        r_state <= StRecover;
                    end
                end
                StRecover: begin
                    if (r_rcv_cnt) begin
                        r_state   <= StNormal;
                        r_rcv_cnt <= 1'b0;
                    end else begin
                        r_rcv_cnt <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= StNormal;
                    r_rcv_cnt <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_upd_valid  <= 1'b0;
            r_upd_taken  <= 1'b0;
            r_upd_pc     <= 32'd0;
            r_upd_target <= 32'd0;
        end else begin
            r_upd_valid <= w_upd_fire;
            if (w_upd_fire) begin
                r_upd_taken  <= w_actual_taken;
                r_upd_pc     <= pc_E;
                r_upd_target <= pc_target_E;
            end
        end
    end

`ifdef BR_PERF_CNT_EN
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    // Both counters saturate at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (r_upd_valid && (r_branch_cnt != {CNT_W{1'b1}})) begin
                r_branch_cnt <= r_branch_cnt + 1'b1;
            end
            if (w_flush && (r_mispred_cnt != {CNT_W{1'b1}})) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
`endif

endmodule

// File: doc/branch_resolve.md
BRANCH_RESOLVE -- requirements
Module: branch_resolve

Interface
REQ-001 Parameter CNT_W, default 32: width of the performance counters.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 taken_F  in  1  fetch-stage prediction: taken when 1.
REQ-005 pred_target_F  in  32  predicted target sent with taken_F.
REQ-006 stall_D  in  1  hazard stall: the D slot holds and a bubble enters E.
REQ-007 branch_E, jump_E, taken_E  in  1 each  resolved instruction class and actual branch outcome in E.
REQ-008 pc_E, pc_target_E  in  32 each  E-stage PC and resolved target.
REQ-009 flush  out  1  mispredict: squash F/D, redirect fetch.
REQ-010 pc_restore  out  32  redirect PC, valid when flush=1.
REQ-011 upd_valid, upd_taken  out  1 each  registered predictor-update strobe and outcome.
REQ-012 upd_pc, upd_target  out  32 each  registered update index PC and target.
REQ-013 branch_cnt, mispred_cnt  out  CNT_W each  performance counters, present only under REQ-031.

Function
REQ-014 The block SHALL carry {valid, pred_taken, pred_target} through a D slot and an E slot, with valid=1 for every fetched instruction.
REQ-015 Each edge SHALL update the slots as follows when stall_D=0 and flush=0: D <= F-side inputs, E <= D.
REQ-016 When stall_D=1 and flush=0, D SHALL hold and E SHALL load a bubble (valid=0).
REQ-017 When flush=1, D and E SHALL both load bubbles at the next edge; flush SHALL take priority over stall_D.
REQ-018 actual_taken SHALL equal jump_E OR (branch_E AND taken_E).
REQ-019 A mispredict SHALL be raised when valid_E=1 and any of the following holds:
  - pred_taken_E differs from actual_taken;
  - pred_taken_E and actual_taken are both 1 and pred_target_E differs from pc_target_E;
  - pred_taken_E=1 while branch_E=0 and jump_E=0.
REQ-020 flush SHALL be combinational from the E slot and E inputs, in the same cycle as the resolving instruction; no mispredict SHALL be raised when valid_E=0.
REQ-021 pc_restore SHALL equal pc_target_E when actual_taken=1, otherwise pc_E+4 (modulo 2^32); it SHALL be 0 when flush=0.
REQ-022 The update strobe SHALL have a latency of 1 cycle: upd_valid SHALL be 1 in the cycle after any valid_E=1 resolution with branch_E or jump_E set.
REQ-023 With the strobe, upd_taken SHALL be actual_taken, upd_pc SHALL be pc_E, and upd_target SHALL be pc_target_E.
REQ-024 In every other cycle, upd_valid SHALL be 0 and upd_* SHALL hold their last values.
REQ-025 A recovery FSM SHALL have states NORMAL and RECOVER:
  - NORMAL -> RECOVER on flush;
  - RECOVER -> NORMAL after exactly 2 cycles, counted by a 1-bit counter;
  - in RECOVER, mispredict evaluation SHALL be masked (flush=0) even if valid_E=1.
REQ-026 Back-to-back mispredicts SHALL be impossible by construction; each mispredict SHALL produce exactly one flush pulse of one cycle.

Reset
REQ-027 While rst=1, all slots SHALL hold valid=0, pred_taken=0 and pred_target=0, and the FSM SHALL be NORMAL.
REQ-028 While rst=1: flush=0, pc_restore=0, upd_valid=0, upd_taken=0, upd_pc=0, upd_target=0, and both counters=0.
REQ-029 Reset asserted mid-recovery SHALL return the FSM to NORMAL immediately and discard any pending update.
REQ-030 After rst deasserts, the first instruction SHALL be evaluable 2 edges after entering the D slot.

Configuration
REQ-031 Macro BR_PERF_CNT_EN controls the performance counters.
  - Defined: branch_cnt SHALL increment on every upd_valid pulse, and mispred_cnt SHALL increment in the cycle after each flush.
  - Both counters SHALL saturate at 2^CNT_W-1.
  - Not defined: branch_cnt and mispred_cnt SHALL NOT exist as ports, and no counter logic SHALL be synthesized.

Verification
REQ-032 Correct taken prediction: taken_F=1, pred_target_F=0x100, resolved with branch_E=1, taken_E=1, pc_target_E=0x100 -> flush=0 and no redirect; next cycle upd_valid=1, upd_taken=1, upd_target=0x100.
REQ-033 Taken prediction not taken: pred taken with pc_E=0x40, resolved branch_E=1, taken_E=0 -> flush=1 and pc_restore=0x44 in that cycle; next cycle D and E hold bubbles and the FSM is RECOVER for 2 cycles.
REQ-034 Wrong target: jump_E=1, predicted 0x200, actual 0x300 -> flush=1, pc_restore=0x300; next cycle upd_taken=1 and upd_target=0x300.
REQ-035 Taken prediction on a non-branch: pred_taken=1, branch_E=0, jump_E=0, pc_E=0xFFFF_FFFC -> flush=1, pc_restore=0x0 (wrap-around), and no upd_valid pulse.
REQ-036 Stall with simultaneous flush: stall_D=1 in the same cycle as a mispredict -> both slots load bubbles; the D slot is not held.
REQ-037 Counters (BR_PERF_CNT_EN, CNT_W=4): 20 resolved branches including 3 mispredicts -> branch_cnt=15 (saturated), mispred_cnt=3; asserting rst -> both read 0.
